// File: rtl/priority_encoder_32_to_5.sv
// Multi-hot request vector to index stream: drains every set bit of one vector, one index per
// handshake. Define ENCODER_ROUND_ROBIN_EN for rotating priority starting after the last grant.
module priority_encoder_32_to_5 #(
    parameter int unsigned N     = 32,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     in_bits_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             out_last_o
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       pending_q, pending_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   start_idle, start_active;
    logic [N-1:0]       rem;

    // First set bit at or above start, wrapping; N is a power of two so IDX_W math wraps.
    function automatic logic [IDX_W-1:0] sel(input logic [N-1:0] v, input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = start + IDX_W'(i);
            if (!found && v[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic one_hot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

`ifdef ENCODER_ROUND_ROBIN_EN
    assign start_idle   = last_grant_q + IDX_W'(1);
    assign start_active = out_idx_q + IDX_W'(1);
`else
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant_q;
    assign start_idle        = '0;
    assign start_active      = '0;
`endif

    assign rem = pending_q & ~({{(N-1){1'b0}}, 1'b1} << out_idx_q);

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        out_idx_d    = out_idx_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        last_grant_d = last_grant_q;
        if (flush_i) begin
            state_d     = StIdle;
            pending_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i && in_bits_i != '0) begin
                        pending_d   = in_bits_i;
                        out_idx_d   = sel(in_bits_i, start_idle);
                        out_valid_d = 1'b1;
                        out_last_d  = one_hot(in_bits_i);
                        state_d     = StActive;
                    end
                end
                StActive: begin
                    if (out_ready_i) begin
                        pending_d    = rem;
                        last_grant_d = out_idx_q;
                        if (rem != '0) begin
                            out_idx_d  = sel(rem, start_active);
                            out_last_d = one_hot(rem);
                        end else begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            state_d     = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            out_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            last_grant_q <= IDX_W'(N - 1);
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            out_idx_q    <= out_idx_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_priority_encoder_32_to_5.sv
// Directed bench for priority_encoder_32_to_5 with an expected-index scoreboard queue.
module tb_priority_encoder_32_to_5;

    typedef struct packed {
        logic [4:0] idx;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_bits = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic        out_last;

    int   n_checks = 0;
    int   n_err = 0;
    int   model_lg = 31;
    int   ticks;
    exp_t exp_q[$];

    priority_encoder_32_to_5 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_bits_i   (in_bits),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic last);
        exp_q.push_back('{idx: 5'(idx), last: last});
    endtask

    // Reference order: ascending, or rotating from the model's last grant.
    task automatic push_vec(input logic [31:0] v);
        int start;
        int cnt;
        int seen;
        int j;
`ifdef ENCODER_ROUND_ROBIN_EN
        start = (model_lg + 1) % 32;
`else
        start = 0;
`endif
        cnt  = $countones(v);
        seen = 0;
        for (int i = 0; i < 32; i++) begin
            j = (start + i) % 32;
            if (v[j]) begin
                seen++;
                push_exp(j, seen == cnt);
            end
        end
    endtask

    task automatic load(input logic [31:0] v);
        in_bits  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Pops and compares on each handshake until n pops, empty queue or bound.
    task automatic drain(input int n, input int bound);
        int   pops;
        exp_t e;
        pops  = 0;
        ticks = 0;
        while (pops < n && exp_q.size() != 0 && ticks < bound) begin
            if (out_valid && out_ready && !flush) begin
                e = exp_q.pop_front();
                chk("out_idx", 32'(out_idx), 32'(e.idx));
                chk("out_last", 32'(out_last), 32'(e.last));
                model_lg = int'(e.idx);
                pops++;
            end
            tick();
            ticks++;
        end
        if (pops < n && exp_q.size() != 0) chk("drain_timeout", 32'(pops), 32'(n));
    endtask

    initial begin
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Three indices on consecutive cycles, in_ready back right after.
        out_ready = 1'b1;
        push_exp(0, 1'b0);
        push_exp(2, 1'b0);
        push_exp(31, 1'b1);
        load(32'h8000_0005);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        drain(3, 10);
        chk("drain_cycles", 32'(ticks), 32'd3);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);

        // Backpressure holds the index stable.
        out_ready = 1'b0;
        push_exp(8, 1'b0);
        push_exp(9, 1'b1);
        load(32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_idx", 32'(out_idx), 32'd8);
            chk("hold_last", 32'(out_last), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        drain(2, 10);
        tick();

        // Zero vector is accepted silently.
        load(32'h0);
        chk("zero_out_valid", 32'(out_valid), 32'd0);
        chk("zero_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("zero_out_valid2", 32'(out_valid), 32'd0);

        // Flush mid-drain beats the simultaneous handshake.
        push_vec(32'hFFFF_FFFF);
        load(32'hFFFF_FFFF);
        drain(4, 10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_last", 32'(out_last), 32'd0);
        push_exp(4, 1'b1);
        load(32'h0000_0010);
        drain(1, 10);
        tick();

        // Priority order after last grant 4.
`ifdef ENCODER_ROUND_ROBIN_EN
        push_exp(7, 1'b0);
        push_exp(0, 1'b1);
`else
        push_exp(0, 1'b0);
        push_exp(7, 1'b1);
`endif
        load(32'h0000_0081);
        drain(2, 10);
        tick();

        // Flush in IDLE drops an offered vector.
        in_bits  = 32'h20;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("idle_flush_valid", 32'(out_valid), 32'd0);
        chk("idle_flush_ready", 32'(in_ready), 32'd1);
        tick();
        chk("idle_flush_valid2", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-drain clears outputs before the next edge.
        push_vec(32'h0000_000F);
        load(32'h0000_000F);
        drain(1, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_idx", 32'(out_idx), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        model_lg = 31;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_after_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
